conv_encoder: RTL

//  Rate-1/2 convolutional encoder: transmit-side counterpart of the Viterbi decoder (BMC/ACS/traceback).

---
 rtl/conv_encoder_if.sv | 23 ++
 rtl/conv_encoder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/conv_encoder_if.sv
// Stream interface of the convolutional encoder: frame start, bit input, symbol output, busy.
// The encoder connects through the slave view; the driving environment uses master.
interface conv_encoder_if;
   logic       start;
   logic       in_valid;
   logic       in_bit;
   logic       in_ready;
   logic       out_valid;
   logic [1:0] out_sym;
   logic       out_last;
   logic       out_ready;
   logic       busy;

   modport master (
      output start, in_valid, in_bit, out_ready,
      input  in_ready, out_valid, out_sym, out_last, busy
   );

   modport slave (
      input  start, in_valid, in_bit, out_ready,
      output in_ready, out_valid, out_sym, out_last, busy
   );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder with zero-tail termination so every frame ends in trellis
// state 0; one data bit per input handshake, one registered 2-bit symbol with valid/ready.
module conv_encoder #(
   parameter int             FRAME_LEN = 8,
   parameter int             K         = 3,
   parameter logic [K-1:0]   G0        = 3'b111,
   parameter logic [K-1:0]   G1        = 3'b101
) (
   input  logic          clk,
   input  logic          rst_n,
   conv_encoder_if.slave bus
);

   localparam int CNT_W  = $clog2(FRAME_LEN + 1);
   localparam int TAIL_W = $clog2(K);

   typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

   function automatic logic parity(input logic [K-1:0] w, input logic [K-1:0] g);
      return ^(w & g);
   endfunction

   state_t             state, state_nxt;
   logic [K-2:0]       sr_p0;
   logic [CNT_W-1:0]   bit_cnt;
   logic [TAIL_W-1:0]  tail_cnt;
   logic [1:0]         sym_p0;
   logic               vld_p0;
   logic               last_p0;

   logic               gen_ok;
   logic               gen;
   logic               gen_u;
   logic               clr;
   logic               set_last;
   logic               data_last;
   logic               in_ready_c;
   logic [K-1:0]       w;

   assign gen_ok    = !vld_p0 || bus.out_ready;
   assign data_last = (bit_cnt == CNT_W'(FRAME_LEN - 1));
   assign w         = {gen_u, sr_p0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      in_ready_c = 1'b0;
      gen        = 1'b0;
      gen_u      = 1'b0;
      clr        = 1'b0;
      set_last   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               clr       = 1'b1;
               state_nxt = DATA;
            end
         end
         DATA: begin
            in_ready_c = gen_ok;
            if (bus.in_valid && gen_ok) begin
               gen   = 1'b1;
               gen_u = bus.in_bit;
               if (data_last) state_nxt = TAIL;
            end
         end
         TAIL: begin
            if (gen_ok) begin
               gen = 1'b1;
               if (tail_cnt == TAIL_W'(K - 2)) begin
                  set_last  = 1'b1;
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            // start arriving in this cycle is deliberately dropped; it must come again in IDLE
            if (vld_p0 && bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_p0    <= '0;
         bit_cnt  <= '0;
         tail_cnt <= '0;
      end else if (clr) begin
         sr_p0    <= '0;
         bit_cnt  <= '0;
         tail_cnt <= '0;
      end else if (gen) begin
         sr_p0 <= w[K-1:1];
         if (state == DATA) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (data_last) tail_cnt <= '0;
         end else begin
            tail_cnt <= tail_cnt + TAIL_W'(1);
         end
      end
   end

   // stage p0: registered output symbol; a drain and a new generate in one cycle keep valid high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sym_p0  <= '0;
         vld_p0  <= 1'b0;
         last_p0 <= 1'b0;
      end else if (gen) begin
         sym_p0  <= {parity(w, G0), parity(w, G1)};
         vld_p0  <= 1'b1;
         last_p0 <= set_last;
      end else if (vld_p0 && bus.out_ready) begin
         vld_p0  <= 1'b0;
         last_p0 <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = vld_p0;
   assign bus.out_sym   = sym_p0;
   assign bus.out_last  = last_p0;
   assign bus.busy      = (state != IDLE);

endmodule
